// File: rtl/pe_pkg.sv
// Shared types and constants for the PE fan-out path.
package pe_pkg;

  typedef enum logic [1:0] {
    BC_IDLE,
    BC_FWD_WAIT,
    BC_SEND,
    BC_BACKOFF
  } bcast_state_t;

  localparam int BC_PORTS = 4;
  localparam int BC_TMR_W = 4;

  // Timer load value for a delay of cyc cycles; zero-cycle delays bypass the timer.
  function automatic logic [BC_TMR_W-1:0] bc_tmr_load(input int unsigned cyc);
    return (cyc == 0) ? '0 : BC_TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/bc_delay_timer.sv
// Loadable down-counter shared by the forward-latency and backoff waits.
module bc_delay_timer
  import pe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [BC_TMR_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic [BC_TMR_W-1:0] value_o,
  output logic                zero_o
);

  logic [BC_TMR_W-1:0] value_q, value_d;
  logic                zero_q;

  // Load wins over decrement; decrement saturates at zero.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i && (value_q != '0)) begin
      value_d = value_q - BC_TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      value_q <= value_d;
      zero_q  <= (value_d == '0);
    end
  end

  assign value_o = value_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/copy4_bcast_ctrl.sv
// 1-to-4 broadcast sequencer: capture one packet, wait, offer it to the masked
// consumers with independent handshakes, back off, then accept the next one.
module copy4_bcast_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned FL_CYC = 2,
  parameter int unsigned BL_CYC = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [BC_PORTS-1:0] in_mask,
  output logic [WIDTH-1:0]    out_data,
  output logic [BC_PORTS-1:0] out_valid,
  input  logic [BC_PORTS-1:0] out_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam logic [BC_TMR_W-1:0] FL_LOAD = bc_tmr_load(FL_CYC);
  localparam logic [BC_TMR_W-1:0] BL_LOAD = bc_tmr_load(BL_CYC);

  bcast_state_t        state_q, state_d;
  logic [BC_PORTS-1:0] pending_q, pending_d;
  logic [BC_PORTS-1:0] out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [BC_PORTS-1:0] hs;

  logic                tmr_load;
  logic [BC_TMR_W-1:0] tmr_load_val;
  logic                tmr_dec;
  logic [BC_TMR_W-1:0] tmr_value;
  logic                tmr_zero;

  bc_delay_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .value_o    (tmr_value),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    data_d       = data_q;
    pkt_cnt_d    = pkt_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    hs           = out_valid_q & out_ready & pending_q;

    case (state_q)
      BC_IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d    = in_data;
          pending_d = in_mask;
          if (in_mask == '0) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
            if (BL_CYC != 0) begin
              state_d      = BC_BACKOFF;
              tmr_load     = 1'b1;
              tmr_load_val = BL_LOAD;
            end
          end else if (FL_CYC == 0) begin
            state_d = BC_SEND;
          end else begin
            state_d      = BC_FWD_WAIT;
            tmr_load     = 1'b1;
            tmr_load_val = FL_LOAD;
          end
        end
      end
      BC_FWD_WAIT: begin
        tmr_dec = (tmr_value != '0);
        if (tmr_zero) state_d = BC_SEND;
      end
      BC_SEND: begin
        // Each accepted bit retires independently; the last one completes the packet.
        pending_d = pending_q & ~hs;
        if (pending_d == '0) begin
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          if (BL_CYC == 0) begin
            state_d = BC_IDLE;
          end else begin
            state_d      = BC_BACKOFF;
            tmr_load     = 1'b1;
            tmr_load_val = BL_LOAD;
          end
        end
      end
      BC_BACKOFF: begin
        tmr_dec = (tmr_value != '0);
        if (tmr_zero) state_d = BC_IDLE;
      end
      default: state_d = BC_IDLE;
    endcase

    out_valid_d = (state_d == BC_SEND) ? pending_d : '0;
    in_ready_d  = (state_d == BC_IDLE);
    busy_d      = (state_d != BC_IDLE);
  end

  // in_ready resets low and rises one cycle later, once IDLE is re-entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BC_IDLE;
      pending_q   <= '0;
      out_valid_q <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_copy4_bcast_ctrl.sv
// Directed bench for copy4_bcast_ctrl: default timing instance plus a
// zero-latency, 2-bit-counter instance, checked against a packet scoreboard.
module tb_copy4_bcast_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_in_valid, a_in_ready, a_busy;
  logic [3:0]  a_in_data, a_in_mask, a_out_data, a_out_valid, a_out_ready;
  logic [15:0] a_pkt_cnt, a_drop_cnt;

  logic        b_in_valid, b_in_ready, b_busy;
  logic [3:0]  b_in_data, b_in_mask, b_out_data, b_out_valid, b_out_ready;
  logic [1:0]  b_pkt_cnt, b_drop_cnt;

  copy4_bcast_ctrl #(.WIDTH(4), .FL_CYC(2), .BL_CYC(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mask(a_in_mask),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .busy(a_busy), .pkt_cnt(a_pkt_cnt), .drop_cnt(a_drop_cnt)
  );

  copy4_bcast_ctrl #(.WIDTH(4), .FL_CYC(0), .BL_CYC(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mask(b_in_mask),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .busy(b_busy), .pkt_cnt(b_pkt_cnt), .drop_cnt(b_drop_cnt)
  );

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pop the oldest expected packet and compare it with the first offer seen.
  task automatic sb_check(input string tag, input logic [3:0] data, input logic [3:0] ov);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed offer %0h with empty scoreboard", tag, ov);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(data), 32'(e.data));
      chk({tag, "_valid"}, 32'(ov), 32'(e.mask));
    end
  endtask

  task automatic a_wait_ready();
    int n = 0;
    while (!a_in_ready && n < 30) begin
      tick();
      n++;
    end
    chk("a_ready_wait", 32'(a_in_ready), 32'(1));
  endtask

  task automatic a_deliver(input logic [3:0] d, input logic [3:0] m);
    int n = 0;
    a_wait_ready();
    a_in_valid  = 1'b1;
    a_in_data   = d;
    a_in_mask   = m;
    a_out_ready = 4'hF;
    exp_q.push_back({d, m});
    tick();
    a_in_valid = 1'b0;
    while (a_out_valid == 4'h0 && n < 30) begin
      tick();
      n++;
    end
    sb_check("a_deliver", a_out_data, a_out_valid);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mask = '0; a_out_ready = '0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mask = '0; b_out_ready = '0;
    tick();
    tick();

    // Reset state
    chk("rst_in_ready", 32'(a_in_ready), 32'(0));
    chk("rst_out_valid", 32'(a_out_valid), 32'(0));
    chk("rst_out_data", 32'(a_out_data), 32'(0));
    chk("rst_busy", 32'(a_busy), 32'(0));
    chk("rst_pkt_cnt", 32'(a_pkt_cnt), 32'(0));
    chk("rst_drop_cnt", 32'(a_drop_cnt), 32'(0));
    chk("rst_b_out_valid", 32'(b_out_valid), 32'(0));
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(a_in_ready), 32'(1));
    chk("post_rst_b_in_ready", 32'(b_in_ready), 32'(1));

    // Test 1: full broadcast, all ready, FL=2 BL=1
    a_in_valid = 1'b1; a_in_data = 4'hA; a_in_mask = 4'hF; a_out_ready = 4'hF;
    exp_q.push_back({4'hA, 4'hF});
    tick();
    a_in_valid = 1'b0;
    chk("t1_c1_valid", 32'(a_out_valid), 32'(0));
    chk("t1_c1_busy", 32'(a_busy), 32'(1));
    chk("t1_c1_in_ready", 32'(a_in_ready), 32'(0));
    tick();
    chk("t1_c2_valid", 32'(a_out_valid), 32'(0));
    tick();
    sb_check("t1_c3", a_out_data, a_out_valid);
    tick();
    chk("t1_c4_valid", 32'(a_out_valid), 32'(0));
    chk("t1_c4_pkt", 32'(a_pkt_cnt), 32'(1));
    chk("t1_c4_in_ready", 32'(a_in_ready), 32'(0));
    tick();
    chk("t1_c5_in_ready", 32'(a_in_ready), 32'(1));
    chk("t1_c5_busy", 32'(a_busy), 32'(0));

    // Test 2: staggered accepts on mask 1011
    a_in_valid = 1'b1; a_in_data = 4'h6; a_in_mask = 4'b1011; a_out_ready = 4'h0;
    exp_q.push_back({4'h6, 4'b1011});
    tick();
    a_in_valid = 1'b0;
    chk("t2_c1_valid", 32'(a_out_valid), 32'(0));
    tick();
    chk("t2_c2_valid", 32'(a_out_valid), 32'(0));
    tick();
    sb_check("t2_c3", a_out_data, a_out_valid);
    a_out_ready = 4'b0001;
    tick();
    chk("t2_c4_valid", 32'(a_out_valid), 32'(4'b1010));
    chk("t2_c4_data", 32'(a_out_data), 32'(4'h6));
    a_out_ready = 4'b0101;
    tick();
    chk("t2_c5_valid", 32'(a_out_valid), 32'(4'b1010));
    a_out_ready = 4'b1000;
    tick();
    chk("t2_c6_valid", 32'(a_out_valid), 32'(4'b0010));
    chk("t2_c6_data", 32'(a_out_data), 32'(4'h6));
    a_out_ready = 4'b0000;
    tick();
    chk("t2_c7_valid", 32'(a_out_valid), 32'(4'b0010));
    tick();
    chk("t2_c8_valid", 32'(a_out_valid), 32'(4'b0010));
    chk("t2_c8_pkt", 32'(a_pkt_cnt), 32'(1));
    a_out_ready = 4'b0010;
    tick();
    a_out_ready = 4'b0000;
    chk("t2_c9_valid", 32'(a_out_valid), 32'(0));
    chk("t2_c9_pkt", 32'(a_pkt_cnt), 32'(2));
    chk("t2_c9_data", 32'(a_out_data), 32'(4'h6));
    tick();
    chk("t2_c10_in_ready", 32'(a_in_ready), 32'(1));

    // Test 3: zero mask drops the packet
    a_in_valid = 1'b1; a_in_data = 4'h5; a_in_mask = 4'h0; a_out_ready = 4'hF;
    tick();
    a_in_valid = 1'b0;
    chk("t3_c1_valid", 32'(a_out_valid), 32'(0));
    chk("t3_c1_drop", 32'(a_drop_cnt), 32'(1));
    chk("t3_c1_in_ready", 32'(a_in_ready), 32'(0));
    chk("t3_c1_busy", 32'(a_busy), 32'(1));
    tick();
    chk("t3_c2_in_ready", 32'(a_in_ready), 32'(1));
    chk("t3_c2_pkt", 32'(a_pkt_cnt), 32'(2));
    chk("t3_c2_valid", 32'(a_out_valid), 32'(0));

    // Test 5: reset during SEND with pending 0110
    a_in_valid = 1'b1; a_in_data = 4'h9; a_in_mask = 4'b0110; a_out_ready = 4'h0;
    exp_q.push_back({4'h9, 4'b0110});
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    sb_check("t5_send", a_out_data, a_out_valid);
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", 32'(a_out_valid), 32'(0));
    chk("t5_rst_pkt", 32'(a_pkt_cnt), 32'(0));
    chk("t5_rst_drop", 32'(a_drop_cnt), 32'(0));
    chk("t5_rst_busy", 32'(a_busy), 32'(0));
    chk("t5_rst_in_ready", 32'(a_in_ready), 32'(0));
    rst = 1'b0;
    tick();
    chk("t5_post_in_ready", 32'(a_in_ready), 32'(1));
    a_deliver(4'h3, 4'hF);
    chk("t5_next_pkt", 32'(a_pkt_cnt), 32'(1));
    chk("t5_next_valid", 32'(a_out_valid), 32'(0));

    // Test 4: FL=0 BL=0 back-to-back with in_valid held
    b_in_valid = 1'b1; b_in_data = 4'h1; b_in_mask = 4'hF; b_out_ready = 4'hF;
    exp_q.push_back({4'h1, 4'hF});
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("t4_pkt_c%0d", i), 32'(b_pkt_cnt), 32'(i / 2));
      if (i % 2 == 1) begin
        sb_check($sformatf("t4_send_c%0d", i), b_out_data, b_out_valid);
        chk($sformatf("t4_in_ready_c%0d", i), 32'(b_in_ready), 32'(0));
        if (i < 5) begin
          b_in_data = b_in_data + 4'h1;
          exp_q.push_back({b_in_data, 4'hF});
        end else begin
          b_in_valid = 1'b0;
        end
      end else begin
        chk($sformatf("t4_idle_valid_c%0d", i), 32'(b_out_valid), 32'(0));
        chk($sformatf("t4_in_ready_c%0d", i), 32'(b_in_ready), 32'(1));
      end
    end

    // Test 6: non-pending ready ignored, then pkt_cnt wraps 3 -> 0 -> 1
    b_in_valid = 1'b1; b_in_data = 4'hC; b_in_mask = 4'b0100; b_out_ready = 4'b1011;
    exp_q.push_back({4'hC, 4'b0100});
    tick();
    b_in_valid = 1'b0;
    sb_check("t6_send", b_out_data, b_out_valid);
    tick();
    chk("t6_held_valid", 32'(b_out_valid), 32'(4'b0100));
    chk("t6_held_pkt", 32'(b_pkt_cnt), 32'(3));
    b_out_ready = 4'hF;
    tick();
    chk("t6_wrap_pkt", 32'(b_pkt_cnt), 32'(0));
    chk("t6_wrap_valid", 32'(b_out_valid), 32'(0));
    chk("t6_wrap_in_ready", 32'(b_in_ready), 32'(1));
    b_in_valid = 1'b1; b_in_data = 4'h7; b_in_mask = 4'b0001;
    exp_q.push_back({4'h7, 4'b0001});
    tick();
    b_in_valid = 1'b0;
    sb_check("t6_last", b_out_data, b_out_valid);
    tick();
    chk("t6_final_pkt", 32'(b_pkt_cnt), 32'(1));
    chk("t6_final_drop", 32'(b_drop_cnt), 32'(0));

    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
